cim_psum_requant: RTL

- Downstream stage of the CIM MAC array. Consumes one signed partial sum per MAC pass (the array's result/done pair).
- Accumulates cfg_tiles partial sums into one output neuron, then adds bias, scales, rounds, applies optional ReLU and saturates to int8.
- Buffers results in a small FIFO behind a valid/ready output toward the activation write-back path.
- Drives a hold signal so the array controller withholds start while results have no guaranteed FIFO space.

---
 rtl/cim_psum_requant_if.sv | 40 ++++
 rtl/cim_psum_requant.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_psum_requant_if.sv
// -----------------------------------------------------------------------------
// cim_psum_requant_if
// Handshake bundle between the CIM MAC array / activation write-back path and
// the partial-sum requantiser.
//   psum_valid / psum_data : one-cycle partial-sum strobe from the MAC array
//   hold                   : requantiser asks the array controller to withhold start
//   out_valid / out_data   : quantised result at the output FIFO head
//   out_ready              : write-back path accepts the head
// modport slave  : the requantiser side
// modport master : the array / write-back side
// -----------------------------------------------------------------------------
interface cim_psum_requant_if #(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 8
);
    logic                        psum_valid;
    logic signed [ACC_WIDTH-1:0] psum_data;
    logic                        hold;
    logic                        out_valid;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        out_ready;

    modport master (
        output psum_valid,
        output psum_data,
        output out_ready,
        input  hold,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  psum_valid,
        input  psum_data,
        input  out_ready,
        output hold,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/cim_psum_requant.sv
// -----------------------------------------------------------------------------
// cim_psum_requant
// Accumulates cfg_tiles signed partial sums from the CIM MAC array into one
// output neuron, adds bias, multiplies by an unsigned scale, rounds with an
// arithmetic right shift (half toward +inf), optionally applies ReLU and
// saturates to a signed OUT_WIDTH value. Results are queued in a small FIFO
// behind a valid/ready output. hold tells the array controller to stop issuing
// starts while FIFO space for further results is not guaranteed.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   cfg_tiles  : partial sums per output (0 behaves as 1)
//   cfg_bias   : signed bias added once per output
//   cfg_scale  : unsigned requant multiplier
//   cfg_shift  : rounding right-shift amount
//   cfg_relu   : clamp negative results to zero
//   bus        : psum strobe in, hold out, output stream (slave modport)
//   err_drop   : sticky, a psum arrived while hold was high and was discarded
//   tile_idx   : partial sums accumulated so far in the current group
//   idle       : no group in progress, pipeline empty, FIFO empty
// -----------------------------------------------------------------------------
module cim_psum_requant #(
    parameter int ACC_WIDTH   = 32,
    parameter int EXT_BITS    = 8,
    parameter int SCALE_WIDTH = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int OUT_WIDTH   = 8,
    parameter int TILE_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic        [TILE_WIDTH-1:0]  cfg_tiles,
    input  logic signed [ACC_WIDTH-1:0]   cfg_bias,
    input  logic        [SCALE_WIDTH-1:0] cfg_scale,
    input  logic        [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic                          cfg_relu,
    cim_psum_requant_if.slave             bus,
    output logic                          err_drop,
    output logic        [TILE_WIDTH-1:0]  tile_idx,
    output logic                          idle
);

    localparam int SUM_W  = ACC_WIDTH + EXT_BITS;
    localparam int PROD_W = SUM_W + SCALE_WIDTH + 1;
    // One extra bit so adding the rounding constant can never overflow.
    localparam int RND_W  = PROD_W + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    // -------------------------------------------------------------------------
    // Rounding / ReLU / saturation helpers
    // -------------------------------------------------------------------------
    function automatic logic signed [RND_W-1:0] round_shift(
        input logic signed [PROD_W-1:0]      p,
        input logic        [SHIFT_WIDTH-1:0] sh
    );
        logic signed [RND_W-1:0] x;
        logic signed [RND_W-1:0] half;
        x = RND_W'(p);
        if (sh == '0) begin
            return x;
        end
        half = RND_W'(1) << (sh - 1'b1);
        return (x + half) >>> sh;
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] relu_sat(
        input logic signed [RND_W-1:0] r_in,
        input logic                    relu
    );
        logic signed [RND_W-1:0] r;
        logic signed [RND_W-1:0] hi;
        logic signed [RND_W-1:0] lo;
        hi = {{(RND_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
        lo = {{(RND_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
        r  = r_in;
        if (relu && (r < 0)) begin
            r = '0;
        end
        if (r > hi) begin
            return hi[OUT_WIDTH-1:0];
        end else if (r < lo) begin
            return lo[OUT_WIDTH-1:0];
        end
        return r[OUT_WIDTH-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // Group tracking and accumulation
    // -------------------------------------------------------------------------
    logic                          hold_q;
    logic                          accept;
    logic                          grp_start;
    logic                          grp_last;
    logic signed [SUM_W-1:0]       acc;
    logic signed [SUM_W-1:0]       acc_base;
    logic signed [SUM_W-1:0]       acc_next;
    logic signed [SUM_W-1:0]       psum_ext;
    logic signed [SUM_W-1:0]       bias_ext;

    // Configuration captured at the first psum of a group.
    logic        [TILE_WIDTH-1:0]  grp_tiles;
    logic signed [ACC_WIDTH-1:0]   grp_bias;
    logic        [SCALE_WIDTH-1:0] grp_scale;
    logic        [SHIFT_WIDTH-1:0] grp_shift;
    logic                          grp_relu;

    // Effective configuration for the psum being accepted this cycle: the live
    // inputs when it opens a group, the captured copy otherwise.
    logic        [TILE_WIDTH-1:0]  cur_tiles;
    logic signed [ACC_WIDTH-1:0]   cur_bias;
    logic        [SCALE_WIDTH-1:0] cur_scale;
    logic        [SHIFT_WIDTH-1:0] cur_shift;
    logic                          cur_relu;

    assign accept    = bus.psum_valid && !hold_q;
    assign grp_start = (tile_idx == '0);

    assign cur_tiles = grp_start ? ((cfg_tiles == '0) ? TILE_WIDTH'(1) : cfg_tiles) : grp_tiles;
    assign cur_bias  = grp_start ? cfg_bias  : grp_bias;
    assign cur_scale = grp_start ? cfg_scale : grp_scale;
    assign cur_shift = grp_start ? cfg_shift : grp_shift;
    assign cur_relu  = grp_start ? cfg_relu  : grp_relu;

    assign grp_last  = accept && ((tile_idx + TILE_WIDTH'(1)) == cur_tiles);

    assign psum_ext  = {{EXT_BITS{bus.psum_data[ACC_WIDTH-1]}}, bus.psum_data};
    assign bias_ext  = {{EXT_BITS{cur_bias[ACC_WIDTH-1]}}, cur_bias};
    // The first psum of a group overwrites rather than adds.
    assign acc_base  = grp_start ? '0 : acc;
    assign acc_next  = acc_base + psum_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (accept && !grp_last) begin
            acc <= acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && grp_start) begin
            grp_tiles <= (cfg_tiles == '0) ? TILE_WIDTH'(1) : cfg_tiles;
            grp_bias  <= cfg_bias;
            grp_scale <= cfg_scale;
            grp_shift <= cfg_shift;
            grp_relu  <= cfg_relu;
        end
    end

    // -------------------------------------------------------------------------
    // S1: bias-added sum of the completed group
    // -------------------------------------------------------------------------
    logic                          vld_p0;
    logic signed [SUM_W-1:0]       sum_p0;
    logic        [SCALE_WIDTH-1:0] scale_p0;
    logic        [SHIFT_WIDTH-1:0] shift_p0;
    logic                          relu_p0;

    always_ff @(posedge clk) begin
        if (grp_last) begin
            sum_p0   <= acc_next + bias_ext;
            scale_p0 <= cur_scale;
            shift_p0 <= cur_shift;
            relu_p0  <= cur_relu;
        end
    end

    // -------------------------------------------------------------------------
    // S2: full-width signed product with the zero-extended scale
    // -------------------------------------------------------------------------
    logic                          vld_p1;
    logic signed [PROD_W-1:0]      prod_p1;
    logic        [SHIFT_WIDTH-1:0] shift_p1;
    logic                          relu_p1;

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            prod_p1  <= PROD_W'(sum_p0) * PROD_W'($signed({1'b0, scale_p0}));
            shift_p1 <= shift_p0;
            relu_p1  <= relu_p0;
        end
    end

    // -------------------------------------------------------------------------
    // S3: round, ReLU, saturate, push into the output FIFO
    // -------------------------------------------------------------------------
    logic signed [OUT_WIDTH-1:0]   q_p2;

    assign q_p2 = relu_sat(round_shift(prod_p1, shift_p1), relu_p1);

    logic signed [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic        [PTR_W-1:0]       wr_ptr;
    logic        [PTR_W-1:0]       rd_ptr;
    logic        [CNT_W-1:0]       fifo_cnt;
    logic        [CNT_W-1:0]       fifo_cnt_next;
    logic        [CNT_W:0]         occ_next;
    logic                          push;
    logic                          pop;
    logic                          out_valid_i;

    assign push        = vld_p1;
    assign out_valid_i = (fifo_cnt != '0);
    assign pop         = out_valid_i && bus.out_ready;

    always_comb begin
        fifo_cnt_next = fifo_cnt;
        if (push && !pop) begin
            fifo_cnt_next = fifo_cnt + CNT_W'(1);
        end else if (!push && pop) begin
            fifo_cnt_next = fifo_cnt - CNT_W'(1);
        end
    end

    // Results that will occupy or are heading for the FIFO after this edge.
    // One slot of margin is left for a start the controller already issued.
    assign occ_next = {1'b0, fifo_cnt_next} + (CNT_W+1)'(grp_last) + (CNT_W+1)'(vld_p0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= q_p2;
        end
    end

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tile_idx <= '0;
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            hold_q   <= 1'b0;
            err_drop <= 1'b0;
        end else begin
            if (accept) begin
                tile_idx <= grp_last ? '0 : (tile_idx + TILE_WIDTH'(1));
            end
            if (bus.psum_valid && hold_q) begin
                err_drop <= 1'b1;
            end
            vld_p0   <= grp_last;
            vld_p1   <= vld_p0;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt <= fifo_cnt_next;
            hold_q   <= (occ_next >= (CNT_W+1)'(FIFO_DEPTH - 1));
        end
    end

    assign bus.hold      = hold_q;
    assign bus.out_valid = out_valid_i;
    assign bus.out_data  = out_valid_i ? mem[rd_ptr] : '0;
    assign idle          = grp_start && !vld_p0 && !vld_p1 && (fifo_cnt == '0);

endmodule
